dfr0520_spi_responder: RTL and testbench
========================================

Name: dfr0520_spi_responder

Overview:
SPI responder (slave) model of the DFR0520 dual 100K digital potentiometer. It receives the 16-bit command/data frames produced by our DFR0520 SPI driver and decodes them into two 8-bit wiper registers and per-channel shutdown flags. It is used as the far-end model in system benches, and on-board as a loopback checker on a second PMOD. SPI pins are oversampled on clk_in; no logic runs on SCK.

Parameters:
FRAME_BITS, 16, required bit count per CS-low window.
WIPER_RESET, 8'h80, wiper value after reset (midscale).
SYNC_STAGES, 2, synchronizer flops on CS, SCK and MOSI (min 2).

Ports:
clk_in  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
CS  input  1  chip select, active low, asynchronous to clk_in.
SCK  input  1  serial clock; MOSI is sampled on its rising edge.
MOSI  input  1  serial data, MSB first.
wiper0  output  8  pot 0 wiper value.
wiper1  output  8  pot 1 wiper value.
shdn0  output  1  pot 0 shutdown flag.
shdn1  output  1  pot 1 shutdown flag.
frame_valid  output  1  1-clk pulse: a good 16-bit frame was decoded.
frame_err  output  1  1-clk pulse: the frame ended with the wrong bit count.
last_cmd  output  2  cmd field of the last valid frame.
last_sel  output  2  sel field of the last valid frame.

Behaviour:
- Reset (rst=1 at a posedge):
  - wiper0 and wiper1 = WIPER_RESET; shdn0, shdn1 = 0; frame_valid, frame_err = 0; last_cmd, last_sel = 0.
  - Shift register and bit counter cleared; synchronizers cleared to CS=1, SCK=0.
  - Reset mid-frame aborts the frame with no register update and no pulse. After reset, bits are accepted only after a new synchronized CS falling edge.
- Input conditioning:
  - CS, SCK and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized signals by comparing with one extra delayed copy.
  - Requirement: SCK high and low phases each ≥ 3 clk_in periods.
- States:
  - IDLE: wait for CS falling edge; clear counter and shift register -> SHIFT.
  - SHIFT: on each SCK rising edge, shift_reg <= {shift_reg[14:0], MOSI_sync} and count += 1. The counter is 5 bits and saturates at 31.
  - SHIFT, CS rising edge -> DONE.
  - DONE (1 clk):
    - count == FRAME_BITS: decode the frame and pulse frame_valid.
    - otherwise: pulse frame_err with no state change.
    - Then go to IDLE.
- Frame format, MSB first: bits[15:14] don't-care; [13:12] cmd; [11:10] don't-care; [9:8] sel; [7:0] data.
- Decode on a valid frame:
  - cmd=01 (write): for each set sel bit (bit0 -> pot 0, bit1 -> pot 1), wiperN <= data and shdnN <= 0.
  - cmd=10 (shutdown): for each set sel bit, shdnN <= 1; wiper unchanged.
  - cmd=00 or 11: no-op, but frame_valid still pulses.
  - sel=00: no pot change, frame_valid still pulses.
  - last_cmd and last_sel are updated on every valid frame.
- Timing: wipers, flags and last_* update on the same edge that frame_valid goes high. frame_valid or frame_err asserts within SYNC_STAGES+3 clk of the pad CS rising edge.
- Simultaneous events:
  - SCK rising edge in the same synchronized cycle as CS rising edge: CS wins; that bit is ignored.
  - SCK edges while CS is high are ignored.
  - Clock-count errors: more than 16 bits -> frame_err; fewer than 16 (including 0, a CS glitch) -> frame_err.
- frame_valid and frame_err are never high together. Outputs are registered, with no combinational path from the pins.

Test Plan:
1. Reset, then idle 20 clk -> wiper0 = wiper1 = 8'h80, shdn = 0, no pulses.
2. Frame 16'h11A5 (cmd=01, sel=01, data=A5) at SCK = clk_in/8 -> one frame_valid; wiper0 = A5, wiper1 = 80; last_cmd = 01, last_sel = 01.
3. Frame 16'h1342 (sel=11), then 16'h2202 (cmd=10, sel=10) -> wiper0 = wiper1 = 42; shdn1 = 1, shdn0 = 0. Then 16'h1277 -> wiper1 = 77, shdn1 = 0.
4. Clock 15 bits, then raise CS -> frame_err once, no register change. Repeat with 17 bits -> frame_err; with 0 bits (CS pulse) -> frame_err.
5. Assert rst after 8 bits of 16'h11FF -> all outputs at reset values, no pulse. The next complete frame 16'h1110 is accepted: wiper0 = 10.
6. Back-to-back frames with CS high for 4 clk, values 16'h1101 then 16'h1202 -> two frame_valid pulses; wiper0 = 01, wiper1 = 02.

Source files
------------

// File: rtl/dfr0520_spi_responder.sv
// SPI responder model of the DFR0520 dual digital potentiometer.
// Pins are oversampled on clk_in; frames decode into two wipers and shutdown flags.
module dfr0520_spi_responder #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter logic [7:0]  WIPER_RESET = 8'h80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       CS,
  input  logic       SCK,
  input  logic       MOSI,
  output logic [7:0] wiper0,
  output logic [7:0] wiper1,
  output logic       shdn0,
  output logic       shdn1,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [1:0] last_cmd,
  output logic [1:0] last_sel
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [4:0] CountMax  = 5'd31;
  localparam logic [4:0] FrameLen  = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_dly_q, sck_dly_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise;

  state_e      state_q, state_d;
  // Bits 15:14 are don't-care, so they simply fall off the top of the shifter.
  logic [13:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic [7:0]  wiper0_q, wiper0_d, wiper1_q, wiper1_d;
  logic        shdn0_q, shdn0_d, shdn1_q, shdn1_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [1:0]  cmd_q, cmd_d, sel_q, sel_d;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_dly_q & ~cs_s;
  assign cs_rise  = ~cs_dly_q & cs_s;
  assign sck_rise = ~sck_dly_q & sck_s;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_dly_q    <= 1'b1;
      sck_dly_q   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_dly_q    <= cs_s;
      sck_dly_q   <= sck_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    wiper0_d = wiper0_q;
    wiper1_d = wiper1_q;
    shdn0_d  = shdn0_q;
    shdn1_d  = shdn1_q;
    cmd_d    = cmd_q;
    sel_d    = sel_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          shift_d = '0;
          count_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // CS rising wins over a coincident SCK edge.
        if (cs_rise) begin
          state_d = StDone;
        end else if (sck_rise) begin
          shift_d = {shift_q[12:0], mosi_s};
          if (count_q != CountMax) count_d = count_q + 5'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (count_q == FrameLen) begin
          valid_d = 1'b1;
          cmd_d   = shift_q[13:12];
          sel_d   = shift_q[9:8];
          if (shift_q[13:12] == 2'b01) begin
            if (shift_q[8]) begin
              wiper0_d = shift_q[7:0];
              shdn0_d  = 1'b0;
            end
            if (shift_q[9]) begin
              wiper1_d = shift_q[7:0];
              shdn1_d  = 1'b0;
            end
          end else if (shift_q[13:12] == 2'b10) begin
            if (shift_q[8]) shdn0_d = 1'b1;
            if (shift_q[9]) shdn1_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      count_q  <= '0;
      wiper0_q <= WIPER_RESET;
      wiper1_q <= WIPER_RESET;
      shdn0_q  <= 1'b0;
      shdn1_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cmd_q    <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      wiper0_q <= wiper0_d;
      wiper1_q <= wiper1_d;
      shdn0_q  <= shdn0_d;
      shdn1_q  <= shdn1_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cmd_q    <= cmd_d;
      sel_q    <= sel_d;
    end
  end

  assign wiper0      = wiper0_q;
  assign wiper1      = wiper1_q;
  assign shdn0       = shdn0_q;
  assign shdn1       = shdn1_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign last_cmd    = cmd_q;
  assign last_sel    = sel_q;

endmodule

// File: tb/tb_dfr0520_spi_responder.sv
// Scoreboard bench for dfr0520_spi_responder: directed frames, then random frames
// and bit counts checked against a behavioural pot model.
module tb_dfr0520_spi_responder;

  localparam int SYNC = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       CS = 1'b1;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic [7:0] wiper0, wiper1;
  logic       shdn0, shdn1, frame_valid, frame_err;
  logic [1:0] last_cmd, last_sel;

  dfr0520_spi_responder #(
    .FRAME_BITS (16),
    .WIPER_RESET(8'h80),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .CS         (CS),
    .SCK        (SCK),
    .MOSI       (MOSI),
    .wiper0     (wiper0),
    .wiper1     (wiper1),
    .shdn0      (shdn0),
    .shdn1      (shdn1),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .last_cmd   (last_cmd),
    .last_sel   (last_sel)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit         err;
    logic [7:0] w0, w1;
    logic       s0, s1;
    logic [1:0] cmd, sel;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  // Behavioural pot state.
  logic [7:0] m_w[2];
  logic       m_s[2];
  logic [1:0] m_cmd, m_sel;

  function automatic void model_reset();
    m_w[0] = 8'h80; m_w[1] = 8'h80;
    m_s[0] = 1'b0;  m_s[1] = 1'b0;
    m_cmd = 2'b00;  m_sel = 2'b00;
  endfunction

  function automatic exp_t snap(bit err);
    exp_t e;
    e.err = err; e.w0 = m_w[0]; e.w1 = m_w[1]; e.s0 = m_s[0]; e.s1 = m_s[1];
    e.cmd = m_cmd; e.sel = m_sel;
    return e;
  endfunction

  // Apply a frame of n bits (last 16 bits sent form the word) and queue the response.
  function automatic void model_frame(logic [31:0] v, int n);
    logic [15:0] w;
    int          cmd, sel;
    if (n != 16) begin
      q.push_back(snap(1'b1));
      return;
    end
    w   = v[15:0];
    cmd = int'(w[13:12]);
    sel = int'(w[9:8]);
    for (int p = 0; p < 2; p++) begin
      if (((sel >> p) & 1) == 1) begin
        if (cmd == 1) begin
          m_w[p] = w[7:0];
          m_s[p] = 1'b0;
        end else if (cmd == 2) begin
          m_s[p] = 1'b1;
        end
      end
    end
    m_cmd = w[13:12];
    m_sel = w[9:8];
    q.push_back(snap(1'b0));
  endfunction

  task automatic clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < SYNC + 4 && q.size() != 0; k++) begin
      @(negedge clk_in);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s: no frame pulse within bound, pending=%0d required=0", name, q.size());
      q.delete();
    end
    clk(1);
  endtask

  task automatic send(input logic [31:0] v, input int n, input int gap, input bit drain,
                      input string name);
    CS = 1'b0;
    clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = v[i];
      clk(4);
      SCK = 1'b1;
      clk(4);
      SCK = 1'b0;
    end
    clk(4);
    model_frame(v, n);
    CS = 1'b1;
    if (drain) wait_drain(name);
    else clk(gap);
  endtask

  task automatic check_state(input string name);
    checks++;
    if (wiper0 !== m_w[0] || wiper1 !== m_w[1] || shdn0 !== m_s[0] || shdn1 !== m_s[1] ||
        last_cmd !== m_cmd || last_sel !== m_sel) begin
      failures++;
      $display("FAIL %s: got w0=%h w1=%h s0=%b s1=%b cmd=%b sel=%b, required w0=%h w1=%h s0=%b s1=%b cmd=%b sel=%b",
               name, wiper0, wiper1, shdn0, shdn1, last_cmd, last_sel,
               m_w[0], m_w[1], m_s[0], m_s[1], m_cmd, m_sel);
    end
  endtask

  // Monitor: every pulse is matched against the next expected response.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst && (frame_valid || frame_err)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got valid=%b err=%b, required no pulse",
                 frame_valid, frame_err);
      end else begin
        e = q.pop_front();
        if (frame_valid !== !e.err || frame_err !== e.err || wiper0 !== e.w0 ||
            wiper1 !== e.w1 || shdn0 !== e.s0 || shdn1 !== e.s1 || last_cmd !== e.cmd ||
            last_sel !== e.sel) begin
          failures++;
          $display("FAIL pulse_compare: got v=%b e=%b w0=%h w1=%h s0=%b s1=%b cmd=%b sel=%b, required v=%b e=%b w0=%h w1=%h s0=%b s1=%b cmd=%b sel=%b",
                   frame_valid, frame_err, wiper0, wiper1, shdn0, shdn1, last_cmd, last_sel,
                   !e.err, e.err, e.w0, e.w1, e.s0, e.s1, e.cmd, e.sel);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    int          n, r;
    model_reset();
    rst = 1'b1;
    clk(3);
    rst = 1'b0;
    clk(20);
    check_state("reset_idle");

    send(32'h11A5, 16, 0, 1'b1, "write_p0");
    check_state("write_p0_state");
    send(32'h1342, 16, 0, 1'b1, "write_both");
    send(32'h2202, 16, 0, 1'b1, "shdn_p1");
    check_state("shdn_p1_state");
    send(32'h1277, 16, 0, 1'b1, "write_p1");
    check_state("write_p1_state");

    send(32'h0000_7FFF, 15, 0, 1'b1, "short15");
    send(32'h0001_2345, 17, 0, 1'b1, "long17");
    send(32'h0, 0, 0, 1'b1, "cs_glitch");
    check_state("err_no_change");

    // Reset in the middle of a frame.
    v = 32'h11FF;
    CS = 1'b0;
    clk(4);
    for (int i = 15; i >= 8; i--) begin
      MOSI = v[i];
      clk(4);
      SCK = 1'b1;
      clk(4);
      SCK = 1'b0;
    end
    rst = 1'b1;
    model_reset();
    CS = 1'b1;
    clk(3);
    rst = 1'b0;
    clk(6);
    check_state("reset_midframe");
    send(32'h1110, 16, 0, 1'b1, "after_reset");
    check_state("after_reset_state");

    send(32'h1101, 16, 4, 1'b0, "b2b_first");
    send(32'h1202, 16, 0, 1'b1, "b2b_second");
    check_state("b2b_state");

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r < 6) n = 16;
      else if (r == 6) n = 15;
      else if (r == 7) n = 17;
      else if (r == 8) n = 0;
      else n = $urandom_range(1, 20);
      v = $urandom;
      send(v, n, 0, 1'b1, "random_frame");
    end
    check_state("random_final");

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
